stepper_axis: RTL

STEPPER_AXIS -- requirements
Module: stepper_axis

---
 rtl/stepper_axis.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/stepper_axis.sv
// stepper_axis: single-axis stepper motor sequencer with 8-entry phase table.
// Optional holding torque in IDLE/DONE when STEPPER_HOLD_EN is defined.
module stepper_axis #(
  parameter int CLK_PER_MS = 50000,
  parameter int STEP_MS    = 5,
  parameter int POS_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_dir_i,
  input  logic [POS_W-1:0] cmd_steps_i,
  input  logic             half_step_i,
  input  logic             pause_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [POS_W-1:0] position_o,
  output logic [3:0]       coil_o
);

  localparam int STEP_TICKS = CLK_PER_MS * STEP_MS;
  localparam int TW = $clog2(STEP_TICKS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(STEP_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q;
  logic [POS_W-1:0] remain_q;
  logic [POS_W-1:0] pos_q;
  logic [2:0]       idx_q;
  logic             dir_q;
  logic             half_q;
  logic             accept;
  logic             busy;
  logic             active;
  logic             expire;
  logic [2:0]       delta;
  logic [3:0]       phase;

  assign busy   = (state_q == RUN) || (state_q == PAUSE);
  assign accept = cmd_valid_i && (state_q == IDLE);
  assign active = busy && !abort_i && !pause_i;
  assign expire = active && (timer_q == T_LAST);
  assign delta  = half_q ? 3'd1 : 3'd2;

  // Next-state logic; abort beats pause, pause beats a step expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i)
          state_d = (cmd_steps_i == '0) ? DONE : RUN;
      end
      RUN, PAUSE: begin
        if (abort_i)
          state_d = IDLE;
        else if (pause_i)
          state_d = PAUSE;
        else if (expire && remain_q == POS_W'(1))
          state_d = DONE;
        else
          state_d = RUN;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Command latch, step timer, remaining count, phase and position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= '0;
      remain_q <= '0;
      pos_q    <= '0;
      idx_q    <= '0;
      dir_q    <= 1'b0;
      half_q   <= 1'b0;
    end else if (accept) begin
      timer_q  <= '0;
      remain_q <= cmd_steps_i;
      dir_q    <= cmd_dir_i;
      half_q   <= half_step_i;
    end else if (busy && abort_i) begin
      timer_q  <= '0;
      remain_q <= '0;
    end else if (active) begin
      if (expire) begin
        timer_q  <= '0;
        remain_q <= remain_q - POS_W'(1);
        idx_q    <= dir_q ? idx_q + delta : idx_q - delta;
        pos_q    <= dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      end else begin
        timer_q  <= timer_q + TW'(1);
      end
    end
  end

  // Phase table lookup.
  always_comb begin
    phase = 4'b0000;
    unique case (idx_q)
      3'd0: phase = 4'b1000;
      3'd1: phase = 4'b1100;
      3'd2: phase = 4'b0100;
      3'd3: phase = 4'b0110;
      3'd4: phase = 4'b0010;
      3'd5: phase = 4'b0011;
      3'd6: phase = 4'b0001;
      3'd7: phase = 4'b1001;
      default: phase = 4'b0000;
    endcase
  end

`ifdef STEPPER_HOLD_EN
  logic moved_q;

  // Remembers whether any step happened since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      moved_q <= 1'b0;
    else if (expire)
      moved_q <= 1'b1;
  end

  // Coils hold the last phase when idle, once the motor has moved.
  always_comb begin
    coil_o = 4'b0000;
    if (busy || moved_q)
      coil_o = phase;
  end
`else
  // Coils energised only while a command is in progress.
  always_comb begin
    coil_o = 4'b0000;
    if (busy)
      coil_o = phase;
  end
`endif

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = busy;
  assign done_o      = (state_q == DONE);
  assign position_o  = pos_q;

endmodule
